vga_sync_receiver: RTL and testbench



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_line_meter.sv | 75 +++++++
 rtl/vga_sync_receiver.sv | 183 ++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : vga_pkg
// Brief   : 640x480@60 timing constants and lock state shared by the VGA path
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package vga_pkg;

  localparam int C_H_DISPLAY   = 640;
  localparam int C_H_FRONT     = 16;
  localparam int C_H_SYNC      = 96;
  localparam int C_H_BACK      = 48;
  localparam int C_H_TOTAL     = C_H_DISPLAY + C_H_FRONT + C_H_SYNC + C_H_BACK;

  localparam int C_V_DISPLAY   = 480;
  localparam int C_V_FRONT     = 10;
  localparam int C_V_SYNC      = 2;
  localparam int C_V_BACK      = 33;
  localparam int C_V_TOTAL     = C_V_DISPLAY + C_V_FRONT + C_V_SYNC + C_V_BACK;

  localparam int C_LOCK_FRAMES = 2;

  localparam int                 C_CNT_W   = 11;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Measurement counters stick at all-ones instead of wrapping.
  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v,
                                                 input logic               en);
    return (en && (v != C_CNT_MAX)) ? v + C_CNT_W'(1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_meter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : vga_line_meter
// Brief   : hsync edge detection, line length / sync / DE width checks
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module vga_line_meter
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = C_H_DISPLAY,
  parameter int H_TOTAL   = C_H_TOTAL,
  parameter int H_SYNC    = C_H_SYNC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               de_in,
  output logic               hs_fall,
  output logic               line_err,
  output logic               line_full,
  output logic [C_CNT_W-1:0] line_len
);

  logic               r_hs_q;
  logic               r_h_valid;
  logic [C_CNT_W-1:0] r_h_cnt;
  logic [C_CNT_W-1:0] r_hs_w;
  logic [C_CNT_W-1:0] r_de_w;
  logic [C_CNT_W-1:0] r_line_len;

  logic               w_hs_fall;
  logic               w_h_sat;
  logic               w_shape_ok;
  logic [C_CNT_W-1:0] w_len;

  assign w_hs_fall  = r_hs_q & ~hsync_in;
  assign w_h_sat    = (r_h_cnt == C_CNT_MAX);
  assign w_len      = sat_inc(r_h_cnt, 1'b1);
  assign w_shape_ok = (w_len  == C_CNT_W'(H_TOTAL)) &&
                      (r_hs_w == C_CNT_W'(H_SYNC))  &&
                      ((r_de_w == '0) || (r_de_w == C_CNT_W'(H_DISPLAY)));

  // A saturated counter is a lost-sync error, raised once while armed.
  assign line_err  = r_h_valid & (w_hs_fall ? ~w_shape_ok : w_h_sat);
  assign line_full = w_hs_fall & (r_de_w == C_CNT_W'(H_DISPLAY));
  assign hs_fall   = w_hs_fall;
  assign line_len  = r_line_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_q     <= 1'b0;
      r_h_valid  <= 1'b0;
      r_h_cnt    <= '0;
      r_hs_w     <= '0;
      r_de_w     <= '0;
      r_line_len <= '0;
    end else begin
      r_hs_q <= hsync_in;
      if (w_hs_fall) begin
        r_h_cnt   <= '0;
        r_hs_w    <= C_CNT_W'(1);
        r_de_w    <= {{(C_CNT_W-1){1'b0}}, de_in};
        r_h_valid <= 1'b1;
        if (r_h_valid) r_line_len <= w_len;
      end else begin
        r_h_cnt <= sat_inc(r_h_cnt, 1'b1);
        r_hs_w  <= sat_inc(r_hs_w, ~hsync_in);
        r_de_w  <= sat_inc(r_de_w, de_in);
        if (w_h_sat) r_h_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : vga_sync_receiver
// Brief   : recovers pixel coordinates and checks VGA timing lock
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int H_DISPLAY   = C_H_DISPLAY,
  parameter int H_TOTAL     = C_H_TOTAL,
  parameter int H_SYNC      = C_H_SYNC,
  parameter int V_DISPLAY   = C_V_DISPLAY,
  parameter int V_TOTAL     = C_V_TOTAL,
  parameter int V_SYNC      = C_V_SYNC,
  parameter int LOCK_FRAMES = C_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic        de_out,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        locked,
  output logic        timing_error,
  output logic [10:0] line_len
);

  localparam logic [7:0] C_LOCK_N = 8'(LOCK_FRAMES);

  logic               w_hs_fall;
  logic               w_line_err;
  logic               w_line_full;

  logic               r_vs_q;
  logic               r_de_q;
  logic               r_de_out;
  logic [9:0]         r_pixel_x;
  logic [9:0]         r_pixel_y;
  logic               r_first_line;

  logic [C_CNT_W-1:0] r_v_cnt;
  logic [C_CNT_W-1:0] r_vs_w;
  logic [C_CNT_W-1:0] r_de_lines;
  logic               r_err_seen;
  logic               r_f_valid;

  lock_state_t        r_state;
  lock_state_t        w_state_next;
  logic [7:0]         r_good_cnt;
  logic [7:0]         w_good_next;
  logic               r_timing_error;

  logic               w_vs_fall;
  logic               w_de_rise;
  logic [C_CNT_W-1:0] w_v_next;
  logic [C_CNT_W-1:0] w_vs_next;
  logic [C_CNT_W-1:0] w_del_next;
  logic               w_frame_ok;
  logic               w_frame_good;
  logic               w_frame_err;
  logic               w_any_err;

  vga_line_meter #(
    .H_DISPLAY (H_DISPLAY),
    .H_TOTAL   (H_TOTAL),
    .H_SYNC    (H_SYNC)
  ) u_line_meter (
    .clk       (clk),
    .reset     (reset),
    .hsync_in  (hsync_in),
    .de_in     (de_in),
    .hs_fall   (w_hs_fall),
    .line_err  (w_line_err),
    .line_full (w_line_full),
    .line_len  (line_len)
  );

  assign w_vs_fall = r_vs_q & ~vsync_in;
  assign w_de_rise = ~r_de_q & de_in;

  // Next-counter values include this cycle's hsync edge so a line that ends
  // on the vsync edge is judged as part of the frame that is closing.
  assign w_v_next   = sat_inc(r_v_cnt, w_hs_fall);
  assign w_vs_next  = sat_inc(r_vs_w, w_hs_fall & ~vsync_in);
  assign w_del_next = sat_inc(r_de_lines, w_line_full);

  assign w_frame_ok   = (w_v_next   == C_CNT_W'(V_TOTAL))   &&
                        (w_vs_next  == C_CNT_W'(V_SYNC))    &&
                        (w_del_next == C_CNT_W'(V_DISPLAY)) &&
                        !r_err_seen && !w_line_err;
  assign w_frame_good = w_vs_fall & r_f_valid & w_frame_ok;
  assign w_frame_err  = w_vs_fall & r_f_valid & ~w_frame_ok;
  assign w_any_err    = w_line_err | w_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_q       <= 1'b0;
      r_de_q       <= 1'b0;
      r_de_out     <= 1'b0;
      r_pixel_x    <= '0;
      r_pixel_y    <= '0;
      r_first_line <= 1'b0;
    end else begin
      r_vs_q   <= vsync_in;
      r_de_q   <= de_in;
      r_de_out <= de_in;
      if (w_de_rise) begin
        r_pixel_x    <= '0;
        r_pixel_y    <= (r_first_line | w_vs_fall) ? 10'd0 : r_pixel_y + 10'd1;
        r_first_line <= 1'b0;
      end else begin
        if (de_in)     r_pixel_x    <= r_pixel_x + 10'd1;
        if (w_vs_fall) r_first_line <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v_cnt    <= '0;
      r_vs_w     <= '0;
      r_de_lines <= '0;
      r_err_seen <= 1'b0;
      r_f_valid  <= 1'b0;
    end else if (w_vs_fall) begin
      r_v_cnt    <= '0;
      r_vs_w     <= '0;
      r_de_lines <= '0;
      r_err_seen <= 1'b0;
      r_f_valid  <= 1'b1;
    end else begin
      r_v_cnt    <= w_v_next;
      r_vs_w     <= w_vs_next;
      r_de_lines <= w_del_next;
      r_err_seen <= r_err_seen | w_line_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= UNLOCKED;
      r_good_cnt     <= '0;
      r_timing_error <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_good_cnt     <= w_good_next;
      r_timing_error <= w_any_err;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    if (w_any_err) begin
      w_state_next = UNLOCKED;
      w_good_next  = '0;
    end else if (w_frame_good) begin
      case (r_state)
        UNLOCKED: begin
          w_good_next  = 8'd1;
          w_state_next = (8'd1 >= C_LOCK_N) ? LOCKED : CHECK;
        end
        CHECK: begin
          w_good_next = r_good_cnt + 8'd1;
          if (r_good_cnt + 8'd1 >= C_LOCK_N) w_state_next = LOCKED;
        end
        default: begin
        end
      endcase
    end
  end

  assign de_out       = r_de_out;
  assign pixel_x      = r_pixel_x;
  assign pixel_y      = r_pixel_y;
  assign locked       = (r_state == LOCKED);
  assign timing_error = r_timing_error;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_vga_sync_receiver
// Brief   : scoreboard bench for vga_sync_receiver on a reduced raster
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_vga_sync_receiver;

  localparam int HD = 16, HF = 2, HS = 3, HT = 24;
  localparam int VD = 6,  VF = 1, VS = 2, VT = 10;
  localparam int LF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        de_out;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        locked;
  logic        timing_error;
  logic [10:0] line_len;

  vga_sync_receiver #(
    .H_DISPLAY (HD), .H_TOTAL (HT), .H_SYNC (HS),
    .V_DISPLAY (VD), .V_TOTAL (VT), .V_SYNC (VS),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .de_in        (de_in),
    .de_out       (de_out),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .locked       (locked),
    .timing_error (timing_error),
    .line_len     (line_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int x; int y; } pix_t;
  pix_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pops one expected coordinate per de_out cycle; also logs pulses.
  int   te_pulses   = 0;
  int   last_te_cyc = -1;
  int   de_cnt      = 0;
  pix_t m_e;
  always @(negedge clk) begin
    if (timing_error === 1'b1) begin
      te_pulses++;
      last_te_cyc = cyc;
    end
    if (de_out === 1'b1) begin
      de_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: de_out=1 with no expected pixel at cycle %0d", cyc);
      end else begin
        m_e = exp_q.pop_front();
        check("pixel_x", int'(pixel_x), m_e.x);
        check("pixel_y", int'(pixel_y), m_e.y);
      end
    end
  end

  // Reference coordinate model, updated from the stimulus stream.
  int m_x = 0, m_y = 0;
  bit m_first = 0, m_de_prev = 0, m_vs_prev = 0;

  task automatic drive(input bit hs, input bit vs, input bit de, input bit rst);
    pix_t p;
    hsync_in = hs; vsync_in = vs; de_in = de; reset = rst;
    if (rst) begin
      m_x = 0; m_y = 0; m_first = 0; m_de_prev = 0; m_vs_prev = 0;
    end else begin
      if (m_vs_prev && !vs) m_first = 1;
      if (de && !m_de_prev) begin
        m_x = 0;
        if (m_first) begin m_y = 0; m_first = 0; end
        else m_y = m_y + 1;
      end else if (de) begin
        m_x = m_x + 1;
      end
      if (de) begin
        p.x = m_x; p.y = m_y;
        exp_q.push_back(p);
      end
      m_de_prev = de; m_vs_prev = vs;
    end
    @(posedge clk);
    #1;
  endtask

  int p_lock_before, p_lock_after, p_len, p_te, p_lock, last_hs_cyc;

  // One raster frame; vsync falls at line VD+VF, column 0.
  task automatic frame(input int stretch_v, input int vs_w, input int probe_v, input int rst_v);
    for (int v = 0; v < VT; v++) begin
      int len;
      len = HT + ((v == stretch_v) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        bit hs, vs, de, rst, vfall;
        hs    = !(h >= HD + HF && h < HD + HF + HS);
        vs    = !(v >= VD + VF && v < VD + VF + vs_w);
        de    = (h < HD) && (v < VD);
        rst   = (v == rst_v) && (h == 5);
        vfall = (h == 0) && (v == VD + VF);
        if (vfall) p_lock_before = int'(locked);
        drive(hs, vs, de, rst);
        if (vfall) p_lock_after = int'(locked);
        if (h == HD + HF) begin
          last_hs_cyc = cyc;
          if (v == probe_v) begin
            p_len  = int'(line_len);
            p_te   = int'(timing_error);
            p_lock = int'(locked);
          end
        end
        if (rst) begin
          check("rst_mid_de_out",  int'(de_out),       0);
          check("rst_mid_pixel_x", int'(pixel_x),      0);
          check("rst_mid_pixel_y", int'(pixel_y),      0);
          check("rst_mid_locked",  int'(locked),       0);
          check("rst_mid_terr",    int'(timing_error), 0);
          check("rst_mid_linelen", int'(line_len),     0);
        end
      end
    end
  endtask

  int te0, de0, hs_ref;

  initial begin
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; reset = 1'b1;
    repeat (2) drive(1, 1, 0, 1);
    check("reset_de_out",  int'(de_out),       0);
    check("reset_pixel_x", int'(pixel_x),      0);
    check("reset_pixel_y", int'(pixel_y),      0);
    check("reset_locked",  int'(locked),       0);
    check("reset_terr",    int'(timing_error), 0);
    check("reset_linelen", int'(line_len),     0);

    // Nominal acquisition: lock right after the third vsync fall.
    frame(-1, VS, -1, -1);
    frame(-1, VS, -1, -1);
    check("lock_after_vs2", p_lock_after, 0);
    frame(-1, VS, -1, -1);
    check("lock_before_vs3", p_lock_before, 0);
    check("lock_after_vs3",  p_lock_after,  1);
    check("nominal_terr_cnt", te_pulses, 0);
    check("nominal_linelen",  int'(line_len), HT);

    de0 = de_cnt;
    frame(-1, VS, -1, -1);
    check("de_per_frame",  de_cnt - de0, HD * VD);
    check("still_locked",  int'(locked), 1);

    // One line stretched by a clock: line error, then frame error at vsync.
    te0 = te_pulses;
    frame(2, VS, 3, -1);
    check("bad_linelen",   p_len,  HT + 1);
    check("bad_terr",      p_te,   1);
    check("bad_unlock",    p_lock, 0);
    check("bad_terr_cnt",  te_pulses - te0, 2);
    frame(-1, VS, -1, -1);
    check("relock_1st_good", p_lock_after, 0);
    frame(-1, VS, -1, -1);
    check("relock_2nd_good", p_lock_after, 1);
    check("relock_terr_cnt", te_pulses - te0, 2);

    // Hsync stalls: single error when h_cnt saturates.
    te0    = te_pulses;
    hs_ref = last_hs_cyc;
    repeat (2300) drive(1, 1, 0, 0);
    check("loss_terr_cnt",  te_pulses - te0, 1);
    check("loss_terr_cyc",  last_te_cyc, hs_ref + 2048);
    check("loss_locked",    int'(locked), 0);

    // Vsync three lines wide: every frame judged bad.
    te0 = te_pulses;
    for (int i = 0; i < 4; i++) begin
      frame(-1, 3, -1, -1);
      check("wide_vs_locked", p_lock_after, 0);
    end
    check("wide_vs_terr_cnt", te_pulses - te0, 4);

    frame(-1, VS, -1, -1);
    frame(-1, VS, -1, -1);
    frame(-1, VS, -1, -1);
    check("recover_lock", p_lock_after, 1);

    // One-cycle reset in the middle of the display area.
    te0 = te_pulses;
    frame(-1, VS, -1, 4);
    check("rst_vs1_lock", p_lock_after, 0);
    frame(-1, VS, -1, -1);
    check("rst_vs2_lock", p_lock_after, 0);
    frame(-1, VS, -1, -1);
    check("rst_vs3_before", p_lock_before, 0);
    check("rst_vs3_lock",   p_lock_after,  1);
    check("rst_terr_cnt",   te_pulses - te0, 0);

    repeat (3) drive(1, 1, 0, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
